// File: rtl/rpn_tokenizer_pkg.sv
// rpn_pkg: types and constants shared by the RPN tokenizer and the stack
// calculator downstream of it.
//   op_t        : calculator op code (nop, negate, add, multiply)
//   tok_state_t : tokenizer control state
//   char_cls_t  : character class of an incoming ASCII byte
//   CH_*        : ASCII constants the tokenizer recognises
//   classify()  : byte -> character class
//   char_op()   : operator byte -> op code
package rpn_pkg;

  typedef enum logic [1:0] {
    OP_NOP = 2'd0,
    OP_NEG = 2'd1,
    OP_ADD = 2'd2,
    OP_MUL = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_NUM      = 2'd1,
    ST_CMD      = 2'd2,
    ST_CMD_PEND = 2'd3
  } tok_state_t;

  typedef enum logic [1:0] {
    CLS_DIGIT = 2'd0,
    CLS_SEP   = 2'd1,
    CLS_OP    = 2'd2,
    CLS_ILL   = 2'd3
  } char_cls_t;

  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_PLUS  = 8'h2B;
  localparam logic [7:0] CH_STAR  = 8'h2A;
  localparam logic [7:0] CH_TILDE = 8'h7E;

  function automatic char_cls_t classify(input logic [7:0] c);
    char_cls_t cls;
    if ((c >= CH_0) && (c <= CH_9)) begin
      cls = CLS_DIGIT;
    end else begin
      case (c)
        CH_SPACE, CH_LF, CH_CR:     cls = CLS_SEP;
        CH_PLUS, CH_STAR, CH_TILDE: cls = CLS_OP;
        default:                    cls = CLS_ILL;
      endcase
    end
    return cls;
  endfunction

  function automatic op_t char_op(input logic [7:0] c);
    op_t op;
    case (c)
      CH_PLUS:  op = OP_ADD;
      CH_STAR:  op = OP_MUL;
      CH_TILDE: op = OP_NEG;
      default:  op = OP_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rpn_tokenizer_if.sv
// rpn_tokenizer_if: character input and command output handshakes of the
// tokenizer.
//   in_valid/in_ready/in_char           : ASCII character stream
//   cmd_valid/cmd_ready                 : command handshake
//   cmd_push/cmd_op/cmd_d               : command fields (push value or op)
// Modports: slave = tokenizer side, master = character source / command sink.
interface rpn_tokenizer_if #(
  parameter int W = 16
);
  import rpn_pkg::*;

  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_char;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_push;
  op_t          cmd_op;
  logic [W-1:0] cmd_d;

  modport slave (
    input  in_valid, in_char, cmd_ready,
    output in_ready, cmd_valid, cmd_push, cmd_op, cmd_d
  );

  modport master (
    output in_valid, in_char, cmd_ready,
    input  in_ready, cmd_valid, cmd_push, cmd_op, cmd_d
  );

endinterface

// File: rtl/rpn_tokenizer_dec_acc.sv
// dec_acc: combinational decimal accumulate step, acc*10 + digit.
//   acc   : current accumulator (W bits)
//   digit : decimal digit 0..9
//   sum   : result modulo 2^W
//   ovf   : exact result did not fit in W bits
module dec_acc #(
  parameter int W = 16
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   digit,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W+3:0] ext_s;
  logic [W+3:0] full_s;

  // x*10 = x*8 + x*2; four guard bits hold any (2^W-1)*10+9 exactly
  always_comb begin
    ext_s  = {4'b0000, acc};
    full_s = (ext_s << 3'd3) + (ext_s << 3'd1) + {{W{1'b0}}, digit};
  end

  assign sum = full_s[W-1:0];
  assign ovf = |full_s[W+3:W];

endmodule

// File: rtl/rpn_tokenizer.sv
// rpn_tokenizer: turns an ASCII character stream into stack calculator
// commands. Decimal literals are accumulated and emitted as push commands
// when a separator or operator terminates them; operators become op
// commands (queued behind the push when they terminate a literal).
//   clk, nrst : clock, synchronous active-low reset
//   bus       : rpn_tokenizer_if slave (character in, command out)
//   err       : sticky, illegal character seen
//   ovf       : sticky, a literal exceeded 2^W-1
module rpn_tokenizer
  import rpn_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           nrst,
  rpn_tokenizer_if.slave bus,
  output logic           err,
  output logic           ovf
);

  tok_state_t   state_r, state_s;
  logic [W-1:0] acc_r, acc_s;
  logic         cmd_valid_r, cmd_valid_s;
  logic         cmd_push_r, cmd_push_s;
  op_t          cmd_op_r, cmd_op_s;
  logic [W-1:0] cmd_d_r, cmd_d_s;
  logic         pend_valid_r, pend_valid_s;
  op_t          pend_op_r, pend_op_s;
  logic         err_r, err_s;
  logic         ovf_r, ovf_s;

  logic         accept_s;
  char_cls_t    cls_s;
  op_t          op_s;
  logic [W-1:0] dec_sum_s;
  logic         dec_ovf_s;

  dec_acc #(.W(W)) u_dec_acc (
    .acc   (acc_r),
    .digit (bus.in_char[3:0]),
    .sum   (dec_sum_s),
    .ovf   (dec_ovf_s)
  );

  // Next-state and next-output logic for the tokenizer FSM
  always_comb begin
    state_s      = state_r;
    acc_s        = acc_r;
    cmd_valid_s  = cmd_valid_r;
    cmd_push_s   = cmd_push_r;
    cmd_op_s     = cmd_op_r;
    cmd_d_s      = cmd_d_r;
    pend_valid_s = pend_valid_r;
    pend_op_s    = pend_op_r;
    err_s        = err_r;
    ovf_s        = ovf_r;
    accept_s     = bus.in_valid && !cmd_valid_r;
    cls_s        = classify(bus.in_char);
    op_s         = char_op(bus.in_char);

    case (state_r)
      ST_IDLE, ST_NUM: begin
        if (accept_s) begin
          case (cls_s)
            CLS_DIGIT: begin
              acc_s   = dec_sum_s;
              ovf_s   = ovf_r | dec_ovf_s;
              state_s = ST_NUM;
            end
            CLS_SEP: begin
              if (state_r == ST_NUM) begin
                cmd_valid_s = 1'b1;
                cmd_push_s  = 1'b1;
                cmd_op_s    = OP_NOP;
                cmd_d_s     = acc_r;
                acc_s       = {W{1'b0}};
                state_s     = ST_CMD;
              end else begin
                state_s = ST_IDLE;
              end
            end
            CLS_OP: begin
              if (state_r == ST_NUM) begin
                // literal goes out first, op waits in the pending slot
                cmd_valid_s  = 1'b1;
                cmd_push_s   = 1'b1;
                cmd_op_s     = OP_NOP;
                cmd_d_s      = acc_r;
                pend_valid_s = 1'b1;
                pend_op_s    = op_s;
                acc_s        = {W{1'b0}};
                state_s      = ST_CMD_PEND;
              end else begin
                cmd_valid_s = 1'b1;
                cmd_push_s  = 1'b0;
                cmd_op_s    = op_s;
                cmd_d_s     = {W{1'b0}};
                state_s     = ST_CMD;
              end
            end
            CLS_ILL: begin
              err_s   = 1'b1;
              acc_s   = {W{1'b0}};
              state_s = ST_IDLE;
            end
            default: begin
              state_s = ST_IDLE;
            end
          endcase
        end else begin
          state_s = state_r;
        end
      end

      ST_CMD: begin
        if (bus.cmd_ready) begin
          cmd_valid_s = 1'b0;
          cmd_push_s  = 1'b0;
          cmd_op_s    = OP_NOP;
          cmd_d_s     = {W{1'b0}};
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_CMD;
        end
      end

      ST_CMD_PEND: begin
        if (bus.cmd_ready) begin
          // push consumed: queued op takes its place on the same edge
          cmd_valid_s  = pend_valid_r;
          cmd_push_s   = 1'b0;
          cmd_op_s     = pend_valid_r ? pend_op_r : OP_NOP;
          cmd_d_s      = {W{1'b0}};
          pend_valid_s = 1'b0;
          pend_op_s    = OP_NOP;
          state_s      = pend_valid_r ? ST_CMD : ST_IDLE;
        end else begin
          state_s = ST_CMD_PEND;
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r      <= ST_IDLE;
      acc_r        <= {W{1'b0}};
      cmd_valid_r  <= 1'b0;
      cmd_push_r   <= 1'b0;
      cmd_op_r     <= OP_NOP;
      cmd_d_r      <= {W{1'b0}};
      pend_valid_r <= 1'b0;
      pend_op_r    <= OP_NOP;
      err_r        <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      state_r      <= state_s;
      acc_r        <= acc_s;
      cmd_valid_r  <= cmd_valid_s;
      cmd_push_r   <= cmd_push_s;
      cmd_op_r     <= cmd_op_s;
      cmd_d_r      <= cmd_d_s;
      pend_valid_r <= pend_valid_s;
      pend_op_r    <= pend_op_s;
      err_r        <= err_s;
      ovf_r        <= ovf_s;
    end
  end

  assign bus.in_ready  = !cmd_valid_r;
  assign bus.cmd_valid = cmd_valid_r;
  assign bus.cmd_push  = cmd_push_r;
  assign bus.cmd_op    = cmd_op_r;
  assign bus.cmd_d     = cmd_d_r;
  assign err           = err_r;
  assign ovf           = ovf_r;

endmodule

// File: tb/tb_rpn_tokenizer.sv
// tb_rpn_tokenizer: self-checking bench for rpn_tokenizer. Table of
// character strings with expected command lists, hand-written handshake
// and reset sequences, and a randomized run against a string-level model.
module tb_rpn_tokenizer;

  logic clk;
  logic nrst;
  logic err;
  logic ovf;

  rpn_tokenizer_if #(.W(16)) ifc ();

  rpn_tokenizer #(.W(16)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc),
    .err  (err),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] chars;
    int          len;
    int          ncmd;
    logic [18:0] c0;
    logic [18:0] c1;
    logic [18:0] c2;
    logic        e;
    logic        o;
  } vec_t;

  vec_t vecs[$];

  // model state for the random run
  int          m_acc;
  bit          m_have;
  bit          m_err;
  bit          m_ovf;
  logic [18:0] exp_q[$];
  bit          hold;
  logic [18:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [18:0] mk_push(input int d);
    logic [31:0] dv;
    dv = d;
    return {1'b1, 2'b00, dv[15:0]};
  endfunction

  function automatic logic [18:0] mk_op(input int op);
    logic [31:0] ov;
    ov = op;
    return {1'b0, ov[1:0], 16'h0000};
  endfunction

  function automatic logic [18:0] cur_cmd();
    return {ifc.cmd_push, ifc.cmd_op, ifc.cmd_d};
  endfunction

  task automatic add_vec(input logic [63:0] s, input int len, input int n,
                         input logic [18:0] c0, input logic [18:0] c1,
                         input logic [18:0] c2, input logic e, input logic o);
    vec_t v;
    v.chars = s; v.len = len; v.ncmd = n;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.e = e; v.o = o;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    nrst = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_char   = 8'h00;
    ifc.cmd_ready = 1'b0;
    repeat (2) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [18:0] got[$];
    logic [18:0] expc;
    logic [7:0]  c;
    int          busy;
    int          budget;
    bit          accepted;
    do_reset();
    ifc.cmd_ready = 1'b1;
    busy = 0;
    for (int i = 0; i < v.len; i++) begin
      c = v.chars[8*(v.len-1-i) +: 8];
      accepted = 1'b0;
      budget = 0;
      while (!accepted && budget <= 20) begin
        @(negedge clk);
        ifc.in_valid = 1'b1;
        ifc.in_char  = c;
        if (!ifc.in_ready) busy++;
        if (ifc.cmd_valid && ifc.cmd_ready) got.push_back(cur_cmd());
        if (ifc.in_ready) accepted = 1'b1;
        else budget++;
      end
      if (!accepted) chk($sformatf("vec%0d_accept_timeout", idx), 32'd0, 32'd1);
    end
    repeat (6) begin
      @(negedge clk);
      ifc.in_valid = 1'b0;
      if (!ifc.in_ready) busy++;
      if (ifc.cmd_valid && ifc.cmd_ready) got.push_back(cur_cmd());
    end
    chk($sformatf("vec%0d_ncmd", idx), got.size(), v.ncmd);
    for (int k = 0; k < v.ncmd && k < got.size(); k++) begin
      case (k)
        0:       expc = v.c0;
        1:       expc = v.c1;
        default: expc = v.c2;
      endcase
      chk($sformatf("vec%0d_cmd%0d", idx, k), {13'd0, got[k]}, {13'd0, expc});
    end
    chk($sformatf("vec%0d_busy", idx), busy, v.ncmd);
    chk($sformatf("vec%0d_err", idx), {31'd0, err}, {31'd0, v.e});
    chk($sformatf("vec%0d_ovf", idx), {31'd0, ovf}, {31'd0, v.o});
  endtask

  task automatic model_char(input logic [7:0] c);
    int v;
    int op;
    op = -1;
    if (c >= 8'h30 && c <= 8'h39) begin
      v = m_acc * 10 + int'(c) - 48;
      if (v > 65535) m_ovf = 1'b1;
      m_acc  = v % 65536;
      m_have = 1'b1;
    end else if (c == 8'h20 || c == 8'h0A || c == 8'h0D) begin
      if (m_have) exp_q.push_back(mk_push(m_acc));
      m_acc = 0; m_have = 1'b0;
    end else begin
      if (c == 8'h2B) op = 2;
      if (c == 8'h2A) op = 3;
      if (c == 8'h7E) op = 1;
      if (op >= 0) begin
        if (m_have) exp_q.push_back(mk_push(m_acc));
        exp_q.push_back(mk_op(op));
      end else begin
        m_err = 1'b1;
      end
      m_acc = 0; m_have = 1'b0;
    end
  endtask

  function automatic logic [7:0] pick_char();
    int r;
    logic [7:0] ill [6];
    logic [7:0] sep [3];
    logic [7:0] ops [3];
    ill = '{8'h61, 8'h2F, 8'h2D, 8'h3A, 8'h00, 8'hFF};
    sep = '{8'h20, 8'h0A, 8'h0D};
    ops = '{8'h2B, 8'h2A, 8'h7E};
    r = int'($urandom_range(0, 19));
    if (r < 9)       return 8'h30 + 8'($urandom_range(0, 9));
    else if (r < 13) return sep[$urandom_range(0, 2)];
    else if (r < 18) return ops[$urandom_range(0, 2)];
    else             return ill[$urandom_range(0, 5)];
  endfunction

  task automatic rand_cycle(input bit drain);
    @(negedge clk);
    if (hold) begin
      chk("rand_hold_valid", {31'd0, ifc.cmd_valid}, 32'd1);
      chk("rand_hold_fields", {13'd0, cur_cmd()}, {13'd0, held});
    end
    if (drain) begin
      ifc.in_valid  = 1'b0;
      ifc.cmd_ready = 1'b1;
    end else begin
      ifc.in_valid  = ($urandom_range(0, 9) < 7);
      ifc.cmd_ready = ($urandom_range(0, 9) < 6);
    end
    ifc.in_char = pick_char();
    if (ifc.in_valid && ifc.in_ready) model_char(ifc.in_char);
    if (ifc.cmd_valid && ifc.cmd_ready) begin
      if (exp_q.size() == 0) chk("rand_extra_cmd", {13'd0, cur_cmd()}, 32'hFFFFFFFF);
      else chk("rand_cmd", {13'd0, cur_cmd()}, {13'd0, exp_q.pop_front()});
    end
    hold = ifc.cmd_valid && !ifc.cmd_ready;
    held = cur_cmd();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_char   = 8'h00;
    ifc.cmd_ready = 1'b0;

    add_vec(64'("12 34+"),   6, 3, mk_push(12),    mk_push(34), mk_op(2), 1'b0, 1'b0);
    add_vec(64'("7~"),       2, 2, mk_push(7),     mk_op(1),    19'd0,    1'b0, 1'b0);
    add_vec(64'("70000 1 "), 8, 2, mk_push(4464),  mk_push(1),  19'd0,    1'b0, 1'b1);
    add_vec(64'("5a6 "),     4, 1, mk_push(6),     19'd0,       19'd0,    1'b1, 1'b0);
    add_vec(64'("65535 "),   6, 1, mk_push(65535), 19'd0,       19'd0,    1'b0, 1'b0);
    add_vec(64'("65536 "),   6, 1, mk_push(0),     19'd0,       19'd0,    1'b0, 1'b1);
    add_vec(64'("  +\n*"),   5, 2, mk_op(2),       mk_op(3),    19'd0,    1'b0, 1'b0);
    add_vec(64'("4\r8\n"),   4, 2, mk_push(4),     mk_push(8),  19'd0,    1'b0, 1'b0);
    add_vec(64'("*"),        1, 1, mk_op(3),       19'd0,       19'd0,    1'b0, 1'b0);
    add_vec(64'("12"),       2, 0, 19'd0,          19'd0,       19'd0,    1'b0, 1'b0);

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_in_ready",  {31'd0, ifc.in_ready},  32'd1);
    chk("rst_cmd_valid", {31'd0, ifc.cmd_valid}, 32'd0);
    chk("rst_cmd_fields", {13'd0, cur_cmd()},    32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // "9*" with back-pressure, then release
    do_reset();
    @(negedge clk); ifc.in_valid = 1'b1; ifc.in_char = 8'h39;
    @(negedge clk); ifc.in_char = 8'h2A;
    @(negedge clk); ifc.in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid",    {31'd0, ifc.cmd_valid}, 32'd1);
      chk("bp_cmd",      {13'd0, cur_cmd()},     {13'd0, mk_push(9)});
      chk("bp_in_ready", {31'd0, ifc.in_ready},  32'd0);
      @(negedge clk);
    end
    ifc.cmd_ready = 1'b1;
    chk("bp_release_push", {13'd0, cur_cmd()}, {13'd0, mk_push(9)});
    @(negedge clk);
    chk("bp_op_valid", {31'd0, ifc.cmd_valid}, 32'd1);
    chk("bp_op_cmd",   {13'd0, cur_cmd()},     {13'd0, mk_op(3)});
    @(negedge clk);
    chk("bp_done_valid", {31'd0, ifc.cmd_valid}, 32'd0);
    chk("bp_done_ready", {31'd0, ifc.in_ready},  32'd1);

    // "3+" with reset while push 3 is held
    do_reset();
    @(negedge clk); ifc.in_valid = 1'b1; ifc.in_char = 8'h33;
    @(negedge clk); ifc.in_char = 8'h2B;
    @(negedge clk); ifc.in_valid = 1'b0;
    chk("mr_held", {13'd0, cur_cmd()}, {13'd0, mk_push(3)});
    nrst = 1'b0;
    @(negedge clk);
    chk("mr_valid", {31'd0, ifc.cmd_valid}, 32'd0);
    chk("mr_ready", {31'd0, ifc.in_ready},  32'd1);
    nrst = 1'b1;
    ifc.cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mr_no_cmd", {31'd0, ifc.cmd_valid}, 32'd0);
    end

    // randomized run against the string-level model
    do_reset();
    m_acc = 0; m_have = 1'b0; m_err = 1'b0; m_ovf = 1'b0;
    hold = 1'b0; held = 19'd0;
    exp_q.delete();
    for (int k = 0; k < 3000; k++) rand_cycle(1'b0);
    for (int k = 0; k < 30; k++) rand_cycle(1'b1);
    chk("rand_leftover", exp_q.size(), 32'd0);
    chk("rand_err", {31'd0, err}, {31'd0, m_err});
    chk("rand_ovf", {31'd0, ovf}, {31'd0, m_ovf});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rpn_tokenizer.md
# rpn_tokenizer

Character-stream front end for the stack calculator. Accepts ASCII characters one at a time over a valid/ready handshake, accumulates decimal literals, and emits one command per handshake: push of a value, or an arithmetic op code. Sits directly upstream of the stack calculator; its `cmd_push`/`cmd_op`/`cmd_d` map onto the calculator's `push`/`op`/`d` inputs.

## Interface
- `W`, 16, literal/data width; must match calculator data width.
- `clk`  in  1  clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  character present on `in_char`.
- `in_ready`  out  1  tokenizer can accept a character this cycle.
- `in_char`  in  8  ASCII character.
- `cmd_valid`  out  1  command held on `cmd_*`.
- `cmd_ready`  in  1  downstream consumes the command this cycle.
- `cmd_push`  out  1  1 = push `cmd_d`, 0 = apply `cmd_op`.
- `cmd_op`  out  2  op code: 0 nop, 1 negate, 2 add, 3 multiply; 0 when `cmd_push`=1.
- `cmd_d`  out  W  literal value; 0 when `cmd_push`=0.
- `err`  out  1  sticky: illegal character seen.
- `ovf`  out  1  sticky: a literal exceeded 2^W-1.

## Operation
- Character classes: `'0'`-`'9'` digit; `' '`, `'\n'`, `'\r'` separator; `'+'` add (2); `'*'` multiply (3); `'~'` negate (1); everything else illegal.
- Internal state: `acc` (W bits), `have_num` flag, command register, `op_pend` (valid + 2-bit op).
- Digit: `acc <= acc*10 + digit` modulo 2^W; `have_num <= 1`; if the exact result exceeds 2^W-1, set `ovf`.
- Separator with `have_num`: load push command with `acc`; clear `acc`, `have_num`. Separator without: no effect.
- Operator without `have_num`: load op command.
- Operator with `have_num`: load push command with `acc`, store op in `op_pend`; clear `acc`, `have_num`. The op command follows the push.
- Illegal character: set `err`; discard pending literal (`acc`=0, `have_num`=0); no command.
- Character accepted only when `in_valid && in_ready`; `in_ready = !cmd_valid`.
- States: IDLE (no cmd, no literal), NUM (literal pending), CMD (push or op held), CMD_PEND (push held, op queued). IDLE-digit->NUM; NUM-separator->CMD; NUM-operator->CMD_PEND; IDLE-operator->CMD; CMD-handshake->IDLE; CMD_PEND-handshake->CMD (op loaded same edge).
- `err`/`ovf` clear only on reset.

## Timing
- Reset: `in_ready`=1, `cmd_valid`=0, `cmd_push`=0, `cmd_op`=0, `cmd_d`=0, `err`=0, `ovf`=0, `acc`=0, `op_pend` cleared. Reset mid-operation drops any held or queued command and partial literal.
- All outputs registered except `in_ready` (combinational from `cmd_valid`).
- Latency: terminating character accepted at edge N -> `cmd_valid`=1 from edge N.
- Push+op pair with `cmd_ready` held high: push valid cycle N, op valid cycle N+1, `in_ready`=1 again cycle N+2.
- Command fields stable while `cmd_valid && !cmd_ready`.
- Multiply by 10 as `(acc<<3)+(acc<<1)` in W+4 bits; overflow = any bit above W-1 set.

## Structure
- Package `rpn_pkg`: `op_t` enum (`OP_NOP`, `OP_NEG`, `OP_ADD`, `OP_MUL` = 0..3), tokenizer state enum, ASCII character constants. Calculator adopts `op_t` for its `op` port.
- Sub-module `dec_acc`: combinational `acc*10+digit` with wrapped result and overflow flag, parameterised by `W`.

## Test plan
- Stream `"12 34+"`, `cmd_ready`=1 -> push 12, push 34, op 2; `err`=`ovf`=0.
- Stream `"7~"` -> push 7 then op 1 on consecutive cycles; `in_ready`=0 for exactly those 2 cycles.
- Stream `"70000 "` -> push 4464 (70000 mod 65536); `ovf`=1 and stays 1 after the next literal.
- Stream `"5a6 "` -> `err`=1; single command push 6; 5 never emitted.
- `"9*"` with `cmd_ready`=0 for 5 cycles -> push 9 held stable, `in_ready`=0; release -> push 9, then op 3.
- `"3+"`, `nrst`=0 while push 3 held -> next cycle `cmd_valid`=0, `in_ready`=1, no op 2 issued after reset release.
